// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: states, decode
// constants, ALU opcodes and datapath mux encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic lw;
    logic sw;
    logic rtype;
    logic itype;
    logic branch;
    logic illegal;
  } iclass_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  localparam logic ALU_ADD  = 1'b1;
  localparam logic ALU_ZERO = 1'b0;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational instruction classifier: one-hot {LW, SW, RTYPE, ITYPE,
// BRANCH, ILLEGAL} from the raw instruction word.
module instr_class import ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output iclass_t               cls
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Opcode/funct match; anything not recognised falls into ILLEGAL
  always_comb begin
    cls = '0;
    case (opcode)
      OP_LOAD:   cls.lw     = (funct3 == F3_LW);
      OP_STORE:  cls.sw     = (funct3 == F3_SW);
      OP_RTYPE:  cls.rtype  = (funct3 == F3_ADD) && (funct7 == F7_ADD);
      OP_ITYPE:  cls.itype  = (funct3 == F3_ADDI);
      OP_BRANCH: cls.branch = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      default:   cls.lw     = 1'b0;
    endcase
    cls.illegal = ~(cls.lw | cls.sw | cls.rtype | cls.itype | cls.branch);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback).
// Optional ILLEGAL_TRAP_EN: illegal decode locks in TRAP and drives `illegal`.
module multicycle_ctrl import ctrl_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     instr,
  input  logic                      eq,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic [1:0]                alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                imm_src,
  output logic [1:0]                result_src,
  output logic                      adr_src,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic                      reg_write,
  output logic                      mem_write,
  output logic                      retire
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                      illegal
`endif
);

  state_t  state;
  state_t  next_state;
  iclass_t cls;

  instr_class #(.DATA_WIDTH(DATA_WIDTH)) u_instr_class (
    .instr (instr),
    .cls   (cls)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (cls.illegal) begin
`ifdef ILLEGAL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;  // NOP: PC already advanced in FETCH
`endif
        end else if (cls.lw || cls.sw) begin
          next_state = S_MEMADR;
        end else if (cls.rtype) begin
          next_state = S_EXECR;
        end else if (cls.itype) begin
          next_state = S_EXECI;
        end else if (cls.branch) begin
          next_state = S_BRANCH;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (cls.lw) begin
          next_state = S_MEMREAD;
        end else begin
          next_state = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
  end

  // Moore decode of datapath controls (imm_src and branch pc_write excepted)
  always_comb begin
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    if (state == S_IDLE) begin
      alu_ctrl = '0;
      imm_src  = IMM_I;
    end else begin
      alu_ctrl = ALU_CTRL_WIDTH'(ALU_ADD);
      imm_src  = imm_sel(instr[6:0]);
    end
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECR: alu_src_a = SRCA_RD1;
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_ctrl  = ALU_CTRL_WIDTH'(ALU_ZERO);
        alu_src_a = SRCA_RD1;
        pc_write  = eq ^ instr[12];  // funct3[0] selects BNE
        retire    = 1'b1;
      end
      default: retire = 1'b0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed latency table, random
// instruction stream against a per-instruction phase model, reset/trap corners.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        eq;
  logic [0:0]  alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic        adr_src, ir_write, pc_write, reg_write, mem_write, retire;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .eq         (eq),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .result_src (result_src),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .retire     (retire)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ill;
    logic       alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ret;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic        e;
    int          cycles;
    int          retires;
    int          pcw;
    int          rw;
    int          mw;
    string       name;
  } tv_t;

  vec_t exp_q[$];
  tv_t  tbl[$];
  localparam vec_t ZERO = '0;

  function automatic vec_t act();
    vec_t v;
    v.ill = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    v.ill = illegal;
`endif
    v.alu = alu_ctrl[0];
    v.a = alu_src_a; v.b = alu_src_b; v.imm = imm_src; v.res = result_src;
    v.adr = adr_src; v.irw = ir_write; v.pcw = pc_write;
    v.rw = reg_write; v.mw = mem_write; v.ret = retire;
    return v;
  endfunction

  function automatic vec_t mk(input logic alu, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] imm, input logic [1:0] res, input logic adr,
                              input logic irw, input logic pcw, input logic rw,
                              input logic mw, input logic ret);
    vec_t v;
    v = '{ill: 1'b0, alu: alu, a: a, b: b, imm: imm, res: res, adr: adr,
          irw: irw, pcw: pcw, rw: rw, mw: mw, ret: ret};
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t exp);
    vec_t a;
    a = act();
    tests++;
    if (a !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: expected output vector for every cycle from FETCH up to next FETCH
  function automatic void model(input logic [31:0] ins, input logic e);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] imm;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    imm = (op == 7'h23) ? 2'd1 : ((op == 7'h63) ? 2'd2 : 2'd0);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 2'd0, 2'd2, imm, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 2'd1, 2'd1, imm, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (op == 7'h03 && f3 == 3'd2) begin
      exp_q.push_back(mk(1'b1, 2'd2, 2'd1, imm, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd0, 2'd0, imm, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd0, 2'd0, imm, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    end else if (op == 7'h23 && f3 == 3'd2) begin
      exp_q.push_back(mk(1'b1, 2'd2, 2'd1, imm, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd0, 2'd0, imm, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    end else if ((op == 7'h33 && f3 == 3'd0 && f7 == 7'd0) || (op == 7'h13 && f3 == 3'd0)) begin
      exp_q.push_back(mk(1'b1, 2'd2, (op == 7'h13) ? 2'd1 : 2'd0, imm, 2'd0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd0, 2'd0, imm, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      exp_q.push_back(mk(1'b0, 2'd2, 2'd0, imm, 2'd0, 1'b0, 1'b0,
                         (f3 == 3'd0) ? e : ~e, 1'b0, 1'b0, 1'b1));
    end
  endfunction

  function automatic logic [31:0] rand_instr(input int kmax);
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, kmax);
    case (k)
      0: return {r[31:15], 3'b010, r[11:7], 7'h03};
      1: return {r[31:15], 3'b010, r[11:7], 7'h23};
      2: return {7'd0, r[24:15], 3'b000, r[11:7], 7'h33};
      3: return {r[31:15], 3'b000, r[11:7], 7'h13};
      4: return {r[31:15], 2'b00, r[12], r[11:7], 7'h63};
      5: return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'h33};
      default: return r;
    endcase
  endfunction

  // Run one instruction from FETCH, tallying until ir_write comes back (bounded)
  task automatic measure(input tv_t t);
    int cyc, nret, npc, nrw, nmw;
    cyc = 0; nret = 0; npc = 0; nrw = 0; nmw = 0;
    instr = t.ins; eq = t.e; #1;
    do begin
      nret += int'(retire); npc += int'(pc_write);
      nrw += int'(reg_write); nmw += int'(mem_write);
      @(posedge clk); #1;
      cyc++;
    end while (!ir_write && cyc < 12);
    check_int({t.name, " cycles"}, cyc, t.cycles);
    check_int({t.name, " retire"}, nret, t.retires);
    check_int({t.name, " pc_write"}, npc, t.pcw);
    check_int({t.name, " reg_write"}, nrw, t.rw);
    check_int({t.name, " mem_write"}, nmw, t.mw);
  endtask

  task automatic run_model(input logic [31:0] ins, input logic e, input string name);
    model(ins, e);
    instr = ins; eq = e; #1;
    for (int p = 0; p < exp_q.size(); p++) begin
      check_vec($sformatf("%s %08h phase%0d", name, ins, p), exp_q[p]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'd0; eq = 1'b0;
    tbl.push_back('{32'h00A00093, 1'b0, 4, 1, 1, 1, 0, "addi"});
    tbl.push_back('{32'h0000A103, 1'b0, 5, 1, 1, 1, 0, "lw"});
    tbl.push_back('{32'h0020A023, 1'b0, 4, 1, 1, 0, 1, "sw"});
    tbl.push_back('{32'h002081B3, 1'b0, 4, 1, 1, 1, 0, "add"});
    tbl.push_back('{32'h00208463, 1'b1, 3, 1, 2, 0, 0, "beq_taken"});
    tbl.push_back('{32'h00208463, 1'b0, 3, 1, 1, 0, 0, "beq_not"});
    tbl.push_back('{32'h00209463, 1'b0, 3, 1, 2, 0, 0, "bne_taken"});
    tbl.push_back('{32'h00209463, 1'b1, 3, 1, 1, 0, 0, "bne_not"});
`ifndef ILLEGAL_TRAP_EN
    tbl.push_back('{32'hFFFFFFFF, 1'b0, 2, 0, 1, 0, 0, "illegal_nop"});
    tbl.push_back('{32'h402081B3, 1'b0, 2, 0, 1, 0, 0, "sub_illegal"});
`endif

    repeat (3) begin
      @(posedge clk); #1;
      check_vec("reset_hold", ZERO);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    check_vec("idle_after_release", ZERO);
    @(posedge clk); #1;
    check_vec("first_fetch", mk(1'b1, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    foreach (tbl[i]) measure(tbl[i]);

    for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
      run_model(rand_instr(4), 1'($urandom_range(0, 1)), "rand");
`else
      run_model(rand_instr(6), 1'($urandom_range(0, 1)), "rand");
`endif
    end

    // Reset asserted while SW sits in MEMWRITE
    model(32'h0020A023, 1'b0);
    instr = 32'h0020A023; eq = 1'b0; #1;
    for (int p = 0; p < 4; p++) begin
      check_vec($sformatf("sw_abort phase%0d", p), exp_q[p]);
      if (p < 3) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0; #1;
    check_vec("sw_abort_immediate", ZERO);
    repeat (2) begin
      @(posedge clk); #1;
      check_vec("sw_abort_hold", ZERO);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    check_vec("sw_abort_idle", ZERO);
    @(posedge clk); #1;
    check_vec("sw_abort_refetch", exp_q[0]);

`ifdef ILLEGAL_TRAP_EN
    instr = 32'hFFFFFFFF; #1;
    check_vec("trap_fetch", mk(1'b1, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check_vec("trap_decode", mk(1'b1, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c < 10; c++) begin
      vec_t tv;
      tv = mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tv.ill = 1'b1;
      @(posedge clk); #1;
      check_vec($sformatf("trap_hold%0d", c), tv);
    end
    rst_n = 1'b0; #1;
    check_vec("trap_reset", ZERO);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
